// File: rtl/key_cmd_if.sv
// Key command bus: raw key inputs toward the front end, board-level commands back out.
interface key_cmd_if;
  logic       key_start;
  logic       key_clear;
  logic       run;
  logic       clr;
  logic [7:0] start_cnt;
  logic       tick;

  // Board side: drives the raw keys, consumes the commands.
  modport master (
    output key_start,
    output key_clear,
    input  run,
    input  clr,
    input  start_cnt,
    input  tick
  );

  // Front end side: consumes the raw keys, produces the commands.
  modport slave (
    input  key_start,
    input  key_clear,
    output run,
    output clr,
    output start_cnt,
    output tick
  );
endinterface

// File: rtl/key_cmd.sv
// Debounced push-button command front end: synchronises two raw keys, filters bounce on
// a slow sample tick and turns clean presses into run/clr/start_cnt commands.
module key_cmd #(
  parameter int unsigned SAMPLE_DIV = 1048576,
  parameter int unsigned DEB_N      = 3
) (
  input logic      clk,
  input logic      reset,
  key_cmd_if.slave bus
);

  localparam int unsigned DivW = $clog2(SAMPLE_DIV);
  // Counter only ever holds 0..DEB_N-1.
  localparam int unsigned CntW = (DEB_N > 1) ? $clog2(DEB_N) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SAMPLE_DIV - 1);
  localparam logic [CntW-1:0] DebLast = CntW'(DEB_N - 1);

  // Bit 0 is the start key, bit 1 the clear key.
  logic [1:0]      raw;
  logic [1:0]      sync1_q;
  logic [1:0]      sync2_q;
  logic [1:0]      level;
  logic [1:0]      level_dly_q;
  logic [1:0]      press_q;
  logic [DivW-1:0] div_q;
  logic [DivW-1:0] div_d;
  logic            tick_q;
  logic            run_q;
  logic            clr_q;
  logic [7:0]      cnt_q;

  assign raw = {bus.key_clear, bus.key_start};

  // Two-flop synchroniser for both raw keys.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Free-running divider next state, wrapping after SAMPLE_DIV-1.
  always_comb begin
    div_d = div_q + DivW'(1);
    if (div_q == DivLast) begin
      div_d = '0;
    end
  end

  // Divider and tick register; tick is high exactly while div_q sits at SAMPLE_DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= (div_d == DivLast);
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_deb
    logic [CntW-1:0] stab_q;
    logic [CntW-1:0] stab_d;
    logic            level_q;
    logic            level_d;

    // Per-key stability counter: DEB_N consecutive disagreeing samples flip the level.
    always_comb begin
      stab_d  = stab_q;
      level_d = level_q;
      if (tick_q) begin
        if (sync2_q[k] == level_q) begin
          stab_d = '0;
        end else if (stab_q == DebLast) begin
          level_d = sync2_q[k];
          stab_d  = '0;
        end else begin
          stab_d = stab_q + CntW'(1);
        end
      end
    end

    // Debounced level and stability counter state.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stab_q  <= '0;
        level_q <= 1'b0;
      end else begin
        stab_q  <= stab_d;
        level_q <= level_d;
      end
    end

    assign level[k] = level_q;
  end

  // Rising-edge detect on the debounced levels; releases produce nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_dly_q <= 2'b00;
      press_q     <= 2'b00;
    end else begin
      level_dly_q <= level;
      press_q     <= level & ~level_dly_q;
    end
  end

  // Command register: clear beats start for run, but a start press still counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= 1'b0;
      clr_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      clr_q <= press_q[1];
      if (press_q[1]) begin
        run_q <= 1'b0;
      end else if (press_q[0]) begin
        run_q <= ~run_q;
      end
      if (press_q[0]) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign bus.run       = run_q;
  assign bus.clr       = clr_q;
  assign bus.start_cnt = cnt_q;
  assign bus.tick      = tick_q;

endmodule

// File: tb/tb_key_cmd.sv
// Bench for key_cmd: directed table, hand-written corner sequences and random key
// activity, all compared cycle by cycle against a window-based reference model.
module tb_key_cmd;

  localparam int unsigned SD = 4;
  localparam int unsigned DN = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  key_cmd_if bus ();

  key_cmd #(
    .SAMPLE_DIV(SD),
    .DEB_N     (DN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: keys seen through a 2-edge delay, sampled every SD edges; a level
  // flips once the last DN samples all disagree with it; a rise reaches the outputs
  // two edges later.
  int          m_n;
  bit          m_d1   [2];
  bit          m_d2   [2];
  bit          m_lvl  [2];
  bit          m_hist [2][DN];
  bit          m_p1   [2];
  bit          m_p2   [2];
  bit          m_run;
  bit          m_clr;
  bit [7:0]    m_cnt;
  bit          m_tick;

  function automatic void model_reset();
    m_n = 0;
    for (int k = 0; k < 2; k++) begin
      m_d1[k] = 0; m_d2[k] = 0; m_lvl[k] = 0; m_p1[k] = 0; m_p2[k] = 0;
      for (int i = 0; i < int'(DN); i++) m_hist[k][i] = 0;
    end
    m_run = 0; m_clr = 0; m_cnt = 8'd0; m_tick = 0;
  endfunction

  function automatic void model_step(bit ks, bit kc);
    bit raw [2];
    bit rose;
    bit all_new;
    raw[0] = ks;
    raw[1] = kc;
    m_n++;
    m_clr = m_p2[1];
    if (m_p2[1]) m_run = 0;
    else if (m_p2[0]) m_run = !m_run;
    if (m_p2[0]) m_cnt = m_cnt + 8'd1;
    for (int k = 0; k < 2; k++) begin
      rose = 0;
      if (m_n % int'(SD) == 0) begin
        for (int i = int'(DN) - 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
        m_hist[k][0] = m_d2[k];
        all_new = 1;
        for (int i = 0; i < int'(DN); i++) if (m_hist[k][i] == m_lvl[k]) all_new = 0;
        if (all_new) begin
          m_lvl[k] = !m_lvl[k];
          rose = m_lvl[k];
        end
      end
      m_p2[k] = m_p1[k];
      m_p1[k] = rose;
      m_d2[k] = m_d1[k];
      m_d1[k] = raw[k];
    end
    m_tick = (m_n % int'(SD) == int'(SD) - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One clock: drive keys, let the edge happen, compare every output against the model.
  task automatic step(input bit ks, input bit kc);
    bus.key_start = ks;
    bus.key_clear = kc;
    @(posedge clk);
    model_step(ks, kc);
    #1;
    n_vec++;
    if ({bus.run, bus.clr, bus.start_cnt, bus.tick} !== {m_run, m_clr, m_cnt, m_tick}) begin
      n_bad++;
      $display("FAIL model t=%0t: got run=%b clr=%b cnt=%0d tick=%b, expected run=%b clr=%b cnt=%0d tick=%b",
               $time, bus.run, bus.clr, bus.start_cnt, bus.tick, m_run, m_clr, m_cnt, m_tick);
    end
  endtask

  // Asynchronous assert, release just after an edge so the next edge is edge 1.
  task automatic do_reset(input int cycles, input bit ks, input bit kc);
    bus.key_start = ks;
    bus.key_clear = kc;
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_async", {bus.run, bus.clr, bus.start_cnt, bus.tick}, 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
    check("reset_release", {bus.run, bus.clr, bus.start_cnt, bus.tick}, 32'd0);
  endtask

  typedef struct {
    bit ks;
    bit kc;
    int hold;
    bit run;
    bit clr;
    int cnt;
  } vec_t;

  vec_t tbl [8];
  int   lat;
  int   clr_seen;
  bit   moved;

  initial begin
    bus.key_start = 1'b0;
    bus.key_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset values and tick phase: high in the 4th, 8th and 12th cycle after release.
    do_reset(3, 1'b0, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      step(1'b0, 1'b0);
      check("tick_phase", bus.tick, (c % int'(SD) == int'(SD) - 1) ? 1 : 0);
    end
    check("reset_outputs", {bus.run, bus.clr, bus.start_cnt}, 32'd0);

    // Directed table: hold each key pattern long enough to settle, then check outputs.
    tbl[0] = '{1, 0, 20, 1, 0, 1};
    tbl[1] = '{0, 0, 20, 1, 0, 1};
    tbl[2] = '{1, 0, 20, 0, 0, 2};
    tbl[3] = '{0, 0, 20, 0, 0, 2};
    tbl[4] = '{1, 0, 20, 1, 0, 3};
    tbl[5] = '{0, 0, 20, 1, 0, 3};
    tbl[6] = '{0, 1, 20, 0, 0, 3};
    tbl[7] = '{0, 0, 20, 0, 0, 3};
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < tbl[r].hold; i++) step(tbl[r].ks, tbl[r].kc);
      check($sformatf("table_row%0d_run", r), bus.run, tbl[r].run);
      check($sformatf("table_row%0d_clr", r), bus.clr, tbl[r].clr);
      check($sformatf("table_row%0d_cnt", r), bus.start_cnt, tbl[r].cnt);
    end

    // Clean press latency, then nothing more while held.
    do_reset(2, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      step(1'b1, 1'b0);
      if (bus.run === 1'b1) lat = i;
    end
    check_rng("press_latency", lat, 13, 16);
    check("press_cnt", bus.start_cnt, 1);
    moved = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0);
      if (bus.run !== 1'b1 || bus.start_cnt !== 8'd1) moved = 1;
    end
    check("held_no_repeat", moved, 0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

    // Clear with run=1: one clr cycle, run low in that cycle, count unchanged.
    clr_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b1);
      if (bus.clr === 1'b1) begin
        clr_seen++;
        check("clear_run_low", bus.run, 0);
        check("clear_cnt_kept", bus.start_cnt, 1);
      end
    end
    check("clear_pulse_count", clr_seen, 1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

    // Bounce rejection: key toggles every 3 cycles for 40 cycles.
    do_reset(2, 1'b0, 1'b0);
    moved = 0;
    for (int i = 0; i < 40; i++) begin
      step(((i / 3) % 2) == 0, 1'b0);
      if (bus.run !== 1'b0 || bus.start_cnt !== 8'd0) moved = 1;
    end
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0);
      if (bus.run !== 1'b0 || bus.start_cnt !== 8'd0) moved = 1;
    end
    check("bounce_rejected", moved, 0);

    // 255 presses, then both keys together: clear wins run, count wraps to 0.
    do_reset(2, 1'b0, 1'b0);
    for (int p = 0; p < 255; p++) begin
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    end
    check("preload_cnt", bus.start_cnt, 255);
    check("preload_run", bus.run, 1);
    clr_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1);
      if (bus.clr === 1'b1) begin
        clr_seen++;
        check("both_run_low", bus.run, 0);
        check("both_cnt_wrap", bus.start_cnt, 0);
      end
    end
    check("both_clr_count", clr_seen, 1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

    // Reset between the 1st and 2nd tick with the key held: progress discarded,
    // one fresh press afterwards.
    do_reset(2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    do_reset(2, 1'b1, 1'b0);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      step(1'b1, 1'b0);
      if (bus.run === 1'b1) lat = i;
    end
    check_rng("reset_mid_latency", lat, 13, 16);
    check("reset_mid_cnt", bus.start_cnt, 1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    check("reset_mid_single", bus.start_cnt, 1);

    // Random key activity with occasional resets.
    do_reset(2, 1'b0, 1'b0);
    for (int s = 0; s < 150; s++) begin
      bit ks;
      bit kc;
      int dur;
      ks  = 1'($urandom_range(0, 1));
      kc  = ($urandom_range(0, 3) == 0);
      dur = int'($urandom_range(1, 24));
      if ($urandom_range(0, 29) == 0) do_reset(int'($urandom_range(1, 3)), ks, kc);
      for (int i = 0; i < dur; i++) step(ks, kc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
